imem_arb: RTL and testbench
===========================

IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning instruction-memory word-address width.
REQ-002 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive loader grants before fetch regains the memory.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetch_addr  in  32  current PC; byte address.
- fetch_instr  out  32  instruction read for the previous-cycle fetch address.
- fetch_valid  out  1  fetch_instr is valid this cycle.
- pc_stall  out  1  hold PC; drives the PC register stall input.
- ld_req  in  1  loader/debug request.
- ld_we  in  1  loader write (1) or read (0).
- ld_addr  in  32  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_ready  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  32  loader read data.
- ld_err  out  1  one-cycle pulse; accepted request was misaligned and suppressed.
- mem_en, mem_we  out  1 each  memory enable and write enable.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  synchronous-read data; 1-cycle latency.

Function
REQ-004 SHALL implement FSM states FETCH, LOAD, RECOVER.
REQ-005 In FETCH, SHALL drive the following, and SHALL assert fetch_valid on the next cycle:
- mem_en=1, mem_we=0.
- mem_addr = fetch_addr[ADDR_WIDTH+1:2].
- pc_stall = ld_req.
REQ-006 FETCH with ld_req=1 SHALL go to LOAD; the in-flight fetch read still completes, with fetch_valid=1 next cycle.
REQ-007 In LOAD, SHALL drive the following, and SHALL never assert fetch_valid for a memory cycle used by LOAD:
- mem_addr = ld_addr[ADDR_WIDTH+1:2], mem_we = ld_we & aligned, mem_wdata = ld_wdata.
- ld_ready = ld_req, pc_stall = 1.
REQ-008 An accepted loader read SHALL produce ld_rvalid=1 with ld_rdata=mem_rdata exactly one cycle after acceptance.
REQ-009 An accepted request with ld_addr[1:0]!=0 SHALL suppress the memory write and SHALL pulse ld_err one cycle after acceptance; no ld_rvalid.
REQ-010 ld_addr bits above ADDR_WIDTH+1 SHALL be ignored, so addresses wrap modulo the memory size.
REQ-011 A burst counter SHALL count accepted loader cycles in LOAD, as follows:
- Transition to RECOVER when the counter reaches MAX_BURST or ld_req=0.
- The counter clears on entry to FETCH.
REQ-012 In RECOVER, SHALL drive mem_addr from fetch_addr with pc_stall=1 and ld_ready=0, then return to FETCH unconditionally.
REQ-013 After RECOVER, fetch SHALL get at least one FETCH cycle, with fetch_valid=1 for the held PC, before any further loader grant.
REQ-014 fetch_instr SHALL equal mem_rdata whenever fetch_valid=1.
REQ-015 Exactly one requester SHALL own the memory per cycle; mem_we SHALL be 0 in all states except LOAD.

Reset
REQ-016 rst=1 SHALL force the following on the next edge, regardless of state, including mid-burst:
- State FETCH, burst counter 0.
- fetch_valid=0, ld_rvalid=0, ld_err=0, ld_ready=0, pc_stall=0, mem_we=0.
REQ-017 A loader transaction interrupted by reset SHALL be dropped, with no write and no response.
REQ-018 During the first cycle after reset release, the arbiter SHALL issue a fetch read of fetch_addr.

Structure
REQ-019 The state enum, its encoding, and the MAX_BURST default SHALL live in shared package pipe_pkg.
REQ-020 The burst/fairness counter SHALL be a natural sub-module, arb_burst_ctr, with clear, increment, and limit-reached outputs; all other logic is flat.

Verification
REQ-021 Idle loader: with PC stepping 0x0,0x4,0x8, the bench SHALL check fetch_valid=1 every cycle, fetch_instr equal to memory words 0,1,2 one cycle later, and pc_stall=0.
REQ-022 Single write: ld_req=1, ld_we=1, ld_addr=0x10, ld_wdata=0xDEADBEEF in FETCH. The bench SHALL check:
- pc_stall=1 immediately.
- LOAD next cycle, with ld_ready=1 and mem_we=1, mem_addr=4.
- Then RECOVER, then FETCH.
- A later read of 0x10 returns 0xDEADBEEF.
REQ-023 Burst fairness: ld_req held high for 10 read cycles with MAX_BURST=4. The bench SHALL check:
- Grants arrive in groups of 4.
- Each group is separated by RECOVER plus at least one fetch_valid=1 cycle.
REQ-024 Misaligned access: write to ld_addr=0x12 SHALL give ld_err=1 one cycle after acceptance, and word 4 SHALL be unchanged.
REQ-025 Reset mid-burst: assert rst during the 2nd LOAD cycle. The bench SHALL check:
- Next cycle: state FETCH, pc_stall=0, ld_ready=0.
- No write from the interrupted cycle.
- Fetch reads resume at fetch_addr.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared arbiter state encoding and burst default for the instruction-memory port.
package pipe_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    LOAD    = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/arb_burst_ctr.sv
// Counts consecutive loader grants; o_limit flags the grant that completes a full burst.
// Count saturates at MAX until cleared, so a stuck loader cannot wrap it.
module arb_burst_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_limit
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CW'(MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Combinational so the arbiter can leave LOAD on the very grant that hits the limit.
  assign o_limit = i_inc && (r_cnt == CW'(MAX - 1));

endmodule

// File: rtl/imem_arb.sv
// Shares one synchronous-read instruction memory between the fetch port and a loader port.
// Fetch data arrives one cycle after its read; the loader is throttled to MAX_BURST grants, then fetch gets the memory back.
module imem_arb
  import pipe_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           fetch_addr,
  output logic [31:0]           fetch_instr,
  output logic                  fetch_valid,
  output logic                  pc_stall,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [31:0]           ld_addr,
  input  logic [31:0]           ld_wdata,
  output logic                  ld_ready,
  output logic                  ld_rvalid,
  output logic [31:0]           ld_rdata,
  output logic                  ld_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_fetch_pend;
  logic       r_ld_rd_pend;
  logic       r_ld_err;
  logic       w_aligned;
  logic       w_limit;
  logic       w_unused;

  assign w_aligned = (ld_addr[1:0] == 2'b00);

  always_comb begin
    w_next   = r_state;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = fetch_addr[ADDR_WIDTH+1:2];
    pc_stall = 1'b0;
    ld_ready = 1'b0;
    case (r_state)
      FETCH: begin
        mem_en   = 1'b1;
        pc_stall = ld_req;
        if (ld_req) w_next = LOAD;
      end
      LOAD: begin
        mem_addr = ld_addr[ADDR_WIDTH+1:2];
        mem_en   = ld_req;
        mem_we   = ld_req & ld_we & w_aligned;
        ld_ready = ld_req;
        pc_stall = 1'b1;
        if (!ld_req || w_limit) w_next = RECOVER;
      end
      RECOVER: begin
        // Re-read the held PC so fetch sees valid data before the loader can win again.
        mem_en   = 1'b1;
        pc_stall = 1'b1;
        w_next   = FETCH;
      end
      default: w_next = FETCH;
    endcase
    // A cycle under reset must neither commit a loader write nor accept a request.
    if (rst) begin
      pc_stall = 1'b0;
      ld_ready = 1'b0;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FETCH;
      r_fetch_pend <= 1'b0;
      r_ld_rd_pend <= 1'b0;
      r_ld_err     <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_fetch_pend <= (r_state != LOAD);
      r_ld_rd_pend <= ld_ready & ~ld_we & w_aligned;
      r_ld_err     <= ld_ready & ~w_aligned;
    end
  end

  arb_burst_ctr #(
    .MAX (MAX_BURST)
  ) u_burst_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state == RECOVER),
    .i_inc   (ld_ready),
    .o_limit (w_limit)
  );

  assign mem_wdata   = ld_wdata;
  assign fetch_valid = r_fetch_pend;
  assign fetch_instr = mem_rdata;
  assign ld_rvalid   = r_ld_rd_pend;
  assign ld_rdata    = mem_rdata;
  assign ld_err      = r_ld_err;

  assign w_unused = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0], ld_addr[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb: vector table for single transactions, scripted burst and reset-mid-burst sequences.
module tb_imem_arb;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_valid;
  logic        pc_stall;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ready;
  logic        ld_rvalid;
  logic [31:0] ld_rdata;
  logic        ld_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  imem_arb #(
    .ADDR_WIDTH (10),
    .MAX_BURST  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_addr  (fetch_addr),
    .fetch_instr (fetch_instr),
    .fetch_valid (fetch_valid),
    .pc_stall    (pc_stall),
    .ld_req      (ld_req),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_ready    (ld_ready),
    .ld_rvalid   (ld_rvalid),
    .ld_rdata    (ld_rdata),
    .ld_err      (ld_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Memory model: word i preloaded with C0DE0000+i on the first edge.
  logic [31:0] mem [0:1023];
  bit          mem_loaded;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE0000 + 32'(i);
      mem_loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        req;
    logic        we;
    logic [31:0] la;
    logic [31:0] wd;
    logic        fv;
    logic        ps;
    logic        rdy;
    logic        rv;
    logic        err;
    logic        mwe;
    logic [9:0]  maddr;
    arb_state_t  st;
    logic [31:0] data;
  } vec_t;

  vec_t  vecs[$];
  int    n_vec = 0;
  int    n_err = 0;
  string tag   = "";

  task automatic chk1(input string nm, input logic act, input logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %b want %b", tag, nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h want %h", tag, nm, act, exp);
    end
  endtask

  task automatic chk_state(input arb_state_t exp);
    chk32("state", {30'b0, dut.r_state}, {30'b0, exp});
  endtask

  initial begin
    int  grants, run, run_base, prev_idx;
    bit  prev_acc, need_gap, saw_rec, saw_fv, done;

    rst = 1'b1; fetch_addr = '0; ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;

    // rst, pc, req, we, la, wd | fv, ps, rdy, rv, err, mwe, maddr, state, data
    vecs.push_back('{1'b1, 32'h00, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, FETCH, 32'h0});
    vecs.push_back('{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, FETCH, 32'h0});
    vecs.push_back('{1'b0, 32'h04, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd1, FETCH, 32'hC0DE0000});
    vecs.push_back('{1'b0, 32'h08, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd2, FETCH, 32'hC0DE0001});
    vecs.push_back('{1'b0, 32'h0C, 1'b0, 1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd3, FETCH, 32'hC0DE0002});
    vecs.push_back('{1'b0, 32'h10, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd4, FETCH, 32'hC0DE0003});
    vecs.push_back('{1'b0, 32'h10, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd4, LOAD, 32'hC0DE0004});
    vecs.push_back('{1'b0, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd4, LOAD, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd4, RECOVER, 32'h0});
    vecs.push_back('{1'b0, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd4, FETCH, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h14, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd5, FETCH, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h14, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd4, LOAD, 32'hC0DE0005});
    vecs.push_back('{1'b0, 32'h14, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd4, LOAD, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h14, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd5, RECOVER, 32'h0});
    vecs.push_back('{1'b0, 32'h14, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd5, FETCH, 32'hC0DE0005});
    vecs.push_back('{1'b0, 32'h18, 1'b1, 1'b1, 32'h12, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd6, FETCH, 32'hC0DE0005});
    vecs.push_back('{1'b0, 32'h18, 1'b1, 1'b1, 32'h12, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd4, LOAD, 32'hC0DE0006});
    vecs.push_back('{1'b0, 32'h18, 1'b0, 1'b1, 32'h12, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'd4, LOAD, 32'h0});
    vecs.push_back('{1'b0, 32'h18, 1'b0, 1'b1, 32'h12, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd6, RECOVER, 32'h0});
    vecs.push_back('{1'b0, 32'h18, 1'b0, 1'b1, 32'h12, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd6, FETCH, 32'hC0DE0006});
    // Loader read of 0x1010 wraps onto word 4, confirming the misaligned write left it intact.
    vecs.push_back('{1'b0, 32'h1C, 1'b1, 1'b0, 32'h1010, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd7, FETCH, 32'hC0DE0006});
    vecs.push_back('{1'b0, 32'h1C, 1'b1, 1'b0, 32'h1010, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'd4, LOAD, 32'hC0DE0007});
    vecs.push_back('{1'b0, 32'h1C, 1'b0, 1'b0, 32'h1010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd4, LOAD, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h1C, 1'b0, 1'b0, 32'h1010, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd7, RECOVER, 32'h0});
    vecs.push_back('{1'b0, 32'h1C, 1'b0, 1'b0, 32'h1010, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd7, FETCH, 32'hC0DE0007});

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; fetch_addr = vecs[i].pc; ld_req = vecs[i].req;
      ld_we = vecs[i].we; ld_addr = vecs[i].la; ld_wdata = vecs[i].wd;
      @(negedge clk);
      tag = $sformatf("v%0d", i);
      n_vec++;
      chk1("fetch_valid", fetch_valid, vecs[i].fv);
      chk1("pc_stall", pc_stall, vecs[i].ps);
      chk1("ld_ready", ld_ready, vecs[i].rdy);
      chk1("ld_rvalid", ld_rvalid, vecs[i].rv);
      chk1("ld_err", ld_err, vecs[i].err);
      chk1("mem_we", mem_we, vecs[i].mwe);
      chk32("mem_addr", {22'b0, mem_addr}, {22'b0, vecs[i].maddr});
      chk_state(vecs[i].st);
      if (vecs[i].fv) chk32("fetch_instr", fetch_instr, vecs[i].data);
      if (vecs[i].rv) chk32("ld_rdata", ld_rdata, vecs[i].data);
      @(posedge clk);
      #1;
    end

    // Burst: 10 reads of words 16..25 with the request held; expect groups of 4,4,2.
    tag = "burst";
    grants = 0; run = 0; run_base = 0; prev_idx = 0;
    prev_acc = 0; need_gap = 0; saw_rec = 0; saw_fv = 0; done = 0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      fetch_addr = 32'h20; ld_we = 1'b0; ld_wdata = '0;
      ld_req  = (grants < 10);
      ld_addr = 32'h40 + 32'(grants) * 32'd4;
      @(negedge clk);
      if (prev_acc) begin
        n_vec++;
        chk1("burst_rvalid", ld_rvalid, 1'b1);
        chk32("burst_rdata", ld_rdata, 32'hC0DE0010 + 32'(prev_idx));
      end
      prev_acc = ld_ready;
      if (ld_ready) begin
        if (need_gap) begin
          n_vec++;
          chk1("burst_gap_recover_then_fetch", saw_rec && saw_fv, 1'b1);
          need_gap = 0;
        end
        if (run == 0) run_base = grants;
        prev_idx = grants;
        grants++;
        run++;
      end else begin
        if (run > 0) begin
          n_vec++;
          chk32("burst_group_len", 32'(run), (10 - run_base >= 4) ? 32'd4 : 32'(10 - run_base));
          run = 0; need_gap = 1; saw_rec = 0; saw_fv = 0;
        end
        if (need_gap && dut.r_state == RECOVER) saw_rec = 1;
        if (need_gap && saw_rec && dut.r_state == FETCH && fetch_valid) saw_fv = 1;
        if (grants == 10 && dut.r_state == FETCH) done = 1;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    chk1("burst_completed_in_budget", done, 1'b1);
    chk32("burst_grant_total", 32'(grants), 32'd10);

    // Reset during the second LOAD cycle of a write burst to words 32,33.
    tag = "rst_mid";
    fetch_addr = 32'h20; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h80; ld_wdata = 32'hBAD00001;
    @(negedge clk);
    n_vec++;
    chk_state(FETCH);
    chk1("pc_stall_req", pc_stall, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    chk_state(LOAD);
    chk1("first_load_we", mem_we, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1; ld_addr = 32'h84; ld_wdata = 32'hBAD00002;
    @(negedge clk);
    n_vec++;
    chk_state(LOAD);
    chk1("we_under_rst", mem_we, 1'b0);
    chk1("ready_under_rst", ld_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    @(negedge clk);
    n_vec++;
    chk_state(FETCH);
    chk1("pc_stall_after_rst", pc_stall, 1'b0);
    chk1("ld_ready_after_rst", ld_ready, 1'b0);
    chk1("ld_rvalid_after_rst", ld_rvalid, 1'b0);
    chk1("ld_err_after_rst", ld_err, 1'b0);
    chk1("fetch_valid_after_rst", fetch_valid, 1'b0);
    chk32("fetch_read_addr", {22'b0, mem_addr}, 32'd8);
    chk32("word33_untouched", mem[33], 32'hC0DE0021);
    chk32("word32_written", mem[32], 32'hBAD00001);
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    chk1("fetch_resumed_valid", fetch_valid, 1'b1);
    chk32("fetch_resumed_instr", fetch_instr, 32'hC0DE0008);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
